instr_encoder: RTL

Inverse of the control unit's decode path: accepts a field-level instruction request (format, opcode, funct3/funct7, register indices, immediate) and packs it into a 32-bit RV32I instruction word.
- Output words are buffered in a 2-entry FIFO and presented on a valid/ready stream that feeds control_unit_if.instr in test harnesses and self-test instruction generators.
- Immediates are range-checked per format; out-of-range requests are consumed, flagged and dropped.

---
 rtl/cpu_types_pkg.sv | 24 ++
 rtl/instr_pack.sv | 55 +++++
 rtl/instr_encoder.sv | 91 +++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word/register aliases, encoder format enum and immediate range limits.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    // Codes 6 and 7 are not members of the enum and are rejected as illegal by the packer.
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } enc_fmt_t;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMM13_MIN = -4096;
    localparam int IMM13_MAX = 4094;
    localparam int IMM21_MIN = -1048576;
    localparam int IMM21_MAX = 1048574;

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer; flags immediates that do not fit the chosen format.
module instr_pack
    import cpu_types_pkg::*;
(
    input  enc_fmt_t    fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  regbits_t    rs1,
    input  regbits_t    rs2,
    input  regbits_t    rd,
    input  word_t       imm,
    output word_t       word,
    output logic        legal
);

    logic signed [31:0] simm;
    assign simm = signed'(imm);

    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (fmt)
            FMT_R: begin
                word  = {funct7, rs2, rs1, funct3, rd, opcode};
                legal = 1'b1;
            end
            FMT_I: begin
                word  = {imm[11:0], rs1, funct3, rd, opcode};
                legal = (simm >= IMM12_MIN) && (simm <= IMM12_MAX);
            end
            FMT_S: begin
                word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                legal = (simm >= IMM12_MIN) && (simm <= IMM12_MAX);
            end
            FMT_B: begin
                word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                legal = (simm >= IMM13_MIN) && (simm <= IMM13_MAX) && !imm[0];
            end
            FMT_U: begin
                word  = {imm[31:12], rd, opcode};
                legal = (imm[11:0] == 12'd0);
            end
            FMT_J: begin
                word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                legal = (simm >= IMM21_MIN) && (simm <= IMM21_MAX) && !imm[0];
            end
            default: begin
                word  = '0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Field-level request to RV32I word encoder with a 2-entry output FIFO, error pulse and pop counter.
module instr_encoder
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       fmt,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  regbits_t         rs1,
    input  regbits_t         rs2,
    input  regbits_t         rd,
    input  word_t            imm,
    output logic             instr_valid,
    input  logic             instr_ready,
    output word_t            instr,
    output logic             imm_err,
    output logic [CNT_W-1:0] enc_count
);

    word_t      mem [2];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] occ;
    logic       ready_en;

    word_t      packed_word;
    logic       packed_legal;
    logic       accept;
    logic       push;
    logic       pop;

    instr_pack u_pack (
        .fmt    (enc_fmt_t'(fmt)),
        .opcode (opcode),
        .funct3 (funct3),
        .funct7 (funct7),
        .rs1    (rs1),
        .rs2    (rs2),
        .rd     (rd),
        .imm    (imm),
        .word   (packed_word),
        .legal  (packed_legal)
    );

    // ready_en keeps req_ready low through reset and until the first edge after release.
    assign req_ready   = ready_en && (occ < 2'(DEPTH));
    assign instr_valid = (occ != 2'd0);
    assign instr       = instr_valid ? mem[rd_ptr] : '0;

    assign accept = req_valid && req_ready;
    assign push   = accept && packed_legal;
    assign pop    = instr_valid && instr_ready;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            occ       <= 2'd0;
            ready_en  <= 1'b0;
            imm_err   <= 1'b0;
            enc_count <= '0;
        end else begin
            ready_en <= 1'b1;
            imm_err  <= accept && !packed_legal;
            if (push) begin
                mem[wr_ptr] <= packed_word;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr    <= ~rd_ptr;
                enc_count <= enc_count + CNT_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule
